// File: rtl/song_sequencer.sv
// Autoplay sequencer: walks one song in ROM, launches one note at a time on the sound unit,
// and handles play/pause/skip/loop. Each launch waits for the unit's "over" flag and then a silent gap.
module song_sequencer #(
  parameter int OCT_W      = 2,
  parameter int NOTE_W     = 3,
  parameter int LEN_W      = 2,
  parameter int SONG_W     = 2,
  parameter int SPAN_LOG2  = 6,
  parameter int GAP_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            play,
  input  logic                            pause,
  input  logic                            skip,
  input  logic                            loop,
  input  logic [SONG_W-1:0]               song_sel,
  output logic [SONG_W+SPAN_LOG2-1:0]     rom_addr,
  input  logic [OCT_W+NOTE_W+LEN_W:0]     rom_data,
  output logic                            snd_start,
  output logic [OCT_W-1:0]                snd_octave,
  output logic [NOTE_W-1:0]               snd_note,
  output logic [LEN_W-1:0]                snd_length,
  input  logic                            snd_over,
  output logic                            busy,
  output logic                            done,
  output logic [SPAN_LOG2-1:0]            note_idx
);

  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, PLAY, GAP, PAUSED, DONE
  } state_t;

  state_t              state, state_nx;
  logic [SONG_W-1:0]   song, song_nx;
  logic [SPAN_LOG2-1:0] idx, idx_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                pend, pend_nx;
  logic                done_nx;
  logic [OCT_W-1:0]    oct_nx;
  logic [NOTE_W-1:0]   note_nx;
  logic [LEN_W-1:0]    len_nx;

  // ROM word layout: {end, octave, note, length}
  logic                rom_end;
  logic [OCT_W-1:0]    rom_oct;
  logic [NOTE_W-1:0]   rom_note;
  logic [LEN_W-1:0]    rom_len;
  logic                idx_last;

  assign rom_end  = rom_data[OCT_W+NOTE_W+LEN_W];
  assign rom_oct  = rom_data[NOTE_W+LEN_W +: OCT_W];
  assign rom_note = rom_data[LEN_W +: NOTE_W];
  assign rom_len  = rom_data[LEN_W-1:0];
  assign idx_last = &idx;

  assign rom_addr  = {song, idx};
  assign note_idx  = idx;
  assign snd_start = (state == START);
  assign busy      = (state != IDLE) && (state != DONE);

  always_comb begin
    state_nx = state;
    song_nx  = song;
    idx_nx   = idx;
    cnt_nx   = cnt;
    pend_nx  = pend;
    done_nx  = 1'b0;
    oct_nx   = snd_octave;
    note_nx  = snd_note;
    len_nx   = snd_length;
    if (!en) begin
      state_nx = IDLE;
      pend_nx  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (play) begin
            state_nx = FETCH;
            song_nx  = song_sel;
            idx_nx   = '0;
            pend_nx  = 1'b0;
          end
        end
        FETCH: begin
          if (pause) pend_nx = 1'b1;
          state_nx = LOAD;
        end
        LOAD: begin
          if (pause) pend_nx = 1'b1;
          if (rom_end) begin
            if (loop) begin
              idx_nx   = '0;
              state_nx = FETCH;
            end else begin
              state_nx = DONE;
              done_nx  = 1'b1;
              pend_nx  = 1'b0;
            end
          end else begin
            oct_nx   = rom_oct;
            note_nx  = rom_note;
            len_nx   = rom_len;
            state_nx = START;
          end
        end
        START: begin
          if (pause) pend_nx = 1'b1;
          state_nx = PLAY;
        end
        PLAY: begin
          // skip loses to pause; the sound unit is left to run out its note
          if (pause) pend_nx = 1'b1;
          if (snd_over || (skip && !pause)) begin
            state_nx = GAP;
            cnt_nx   = GAP_LOAD;
          end
        end
        GAP: begin
          if (pause) pend_nx = 1'b1;
          if (cnt == '0) begin
            if (idx_last && !loop) begin
              state_nx = DONE;
              done_nx  = 1'b1;
              pend_nx  = 1'b0;
            end else begin
              idx_nx = idx + 1'b1;
              if (pend || pause) begin
                state_nx = PAUSED;
                pend_nx  = 1'b0;
              end else begin
                state_nx = FETCH;
              end
            end
          end else if (skip && !pause) begin
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        PAUSED: begin
          if (!pause) begin
            if (skip) begin
              if (idx_last && !loop) begin
                state_nx = DONE;
                done_nx  = 1'b1;
              end else begin
                idx_nx = idx + 1'b1;
              end
            end else if (play) begin
              state_nx = FETCH;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      song       <= '0;
      idx        <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      done       <= 1'b0;
      snd_octave <= '0;
      snd_note   <= '0;
      snd_length <= '0;
    end else begin
      state      <= state_nx;
      song       <= song_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      pend       <= pend_nx;
      done       <= done_nx;
      snd_octave <= oct_nx;
      snd_note   <= note_nx;
      snd_length <= len_nx;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: synchronous ROM and a fixed-duration sound unit model,
// expected note launches queued at stimulus time and popped on each snd_start.
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, play, pause, skip, loop;
  logic [1:0] song_sel;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic       snd_start;
  logic [1:0] snd_octave;
  logic [2:0] snd_note;
  logic [1:0] snd_length;
  logic       snd_over;
  logic       busy, done;
  logic [5:0] note_idx;

  logic [7:0]  rom [0:255];
  logic [14:0] exp_q [$];
  logic [14:0] exp_e;
  int scnt = 0;
  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int last_start = 0;
  int prev_start = 0;

  always #5 clk = ~clk;

  song_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .play(play), .pause(pause), .skip(skip), .loop(loop),
    .song_sel(song_sel), .rom_addr(rom_addr), .rom_data(rom_data), .snd_start(snd_start),
    .snd_octave(snd_octave), .snd_note(snd_note), .snd_length(snd_length), .snd_over(snd_over),
    .busy(busy), .done(done), .note_idx(note_idx)
  );

  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk) cyc <= cyc + 1;

  // Sound unit: each note keeps "over" low for 4 cycles after the start edge
  always @(posedge clk) begin
    if (snd_start) scnt <= 4;
    else if (scnt > 0) scnt <= scnt - 1;
  end
  assign snd_over = (scnt == 0);

  always @(negedge clk) begin
    if (snd_start) begin
      start_cnt  = start_cnt + 1;
      prev_start = last_start;
      last_start = cyc;
      vectors    = vectors + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_start: got addr=%0d fields=%h, required no launch",
                 rom_addr, {snd_octave, snd_note, snd_length});
      end else begin
        exp_e = exp_q.pop_front();
        if ({rom_addr, snd_octave, snd_note, snd_length} !== exp_e) begin
          errors = errors + 1;
          $display("FAIL launch: got addr/fields=%h, required %h",
                   {rom_addr, snd_octave, snd_note, snd_length}, exp_e);
        end
      end
    end
    if (done) done_cnt = done_cnt + 1;
  end

  function automatic logic [7:0] ent(input logic e, input logic [1:0] o,
                                     input logic [2:0] n, input logic [1:0] l);
    return {e, o, n, l};
  endfunction

  task automatic push_exp(input logic [7:0] addr);
    exp_q.push_back({addr, rom[addr][6:0]});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_play();
    @(posedge clk); #1 play = 1'b1;
    @(posedge clk); #1 play = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget);
    for (int i = 0; i < budget && start_cnt < target; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; play = 1'b0; pause = 1'b0; skip = 1'b0; loop = 1'b0; song_sel = 2'd0;
    step(3);
    vectors++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d, required 0", rom_addr); end
    vectors++; if (note_idx !== 6'd0) begin errors++; $display("FAIL reset_idx: got %0d, required 0", note_idx); end
    vectors++; if ({snd_octave, snd_note, snd_length} !== 7'd0) begin errors++; $display("FAIL reset_snd: got %h, required 0", {snd_octave, snd_note, snd_length}); end
    vectors++; if (snd_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b, required 0", snd_start); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    rst = 1'b0; en = 1'b1;
    step(6);
  endtask

  task automatic test_basic();
    int s0, d0;
    s0 = start_cnt; d0 = done_cnt; loop = 1'b0; song_sel = 2'd0;
    for (int a = 0; a < 3; a++) push_exp(8'(a));
    pulse_play();
    wait_done(d0 + 1, 300);
    step(4);
    vectors++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done: got %0d pulses, required 1", done_cnt - d0); end
    vectors++; if (start_cnt - s0 !== 3) begin errors++; $display("FAIL basic_starts: got %0d, required 3", start_cnt - s0); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b, required 0", busy); end
    vectors++; if (last_start - prev_start !== 24) begin errors++; $display("FAIL basic_spacing: got %0d cycles, required 24", last_start - prev_start); end
    vectors++; if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_pending: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_loop();
    int s0, d0;
    s0 = start_cnt; d0 = done_cnt; loop = 1'b1; song_sel = 2'd0;
    push_exp(8'd0); push_exp(8'd1); push_exp(8'd2); push_exp(8'd0);
    pulse_play();
    wait_starts(s0 + 4, 400);
    @(posedge clk); #1 en = 1'b0;
    step(1);
    vectors++; if (start_cnt - s0 !== 4) begin errors++; $display("FAIL loop_starts: got %0d, required 4", start_cnt - s0); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_abort_busy: got %b, required 0", busy); end
    vectors++; if (done_cnt !== d0) begin errors++; $display("FAIL loop_done: got %0d pulses, required 0", done_cnt - d0); end
    en = 1'b1; loop = 1'b0;
    step(30);
    vectors++; if (start_cnt - s0 !== 4) begin errors++; $display("FAIL loop_quiet: got %0d, required 4", start_cnt - s0); end
    vectors++; if (exp_q.size() !== 0) begin errors++; $display("FAIL loop_pending: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_pause();
    int s0, d0;
    s0 = start_cnt; d0 = done_cnt; loop = 1'b0; song_sel = 2'd0;
    push_exp(8'd0); push_exp(8'd1);
    pulse_play();
    wait_starts(s0 + 2, 200);
    @(posedge clk); #1 pause = 1'b1;
    @(posedge clk); #1 pause = 1'b0;
    step(40);
    vectors++; if (note_idx !== 6'd2) begin errors++; $display("FAIL pause_idx: got %0d, required 2", note_idx); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL pause_busy: got %b, required 1", busy); end
    vectors++; if (start_cnt - s0 !== 2) begin errors++; $display("FAIL pause_starts: got %0d, required 2", start_cnt - s0); end
    push_exp(8'd2);
    pulse_play();
    wait_done(d0 + 1, 200);
    step(3);
    vectors++; if (start_cnt - s0 !== 3) begin errors++; $display("FAIL resume_starts: got %0d, required 3", start_cnt - s0); end
    vectors++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL resume_done: got %0d, required 1", done_cnt - d0); end
    exp_q.delete();
  endtask

  task automatic test_skip();
    int s0, d0;
    s0 = start_cnt; d0 = done_cnt; loop = 1'b0; song_sel = 2'd0;
    for (int a = 0; a < 3; a++) push_exp(8'(a));
    pulse_play();
    wait_starts(s0 + 1, 200);
    @(posedge clk); #1 skip = 1'b1;
    @(posedge clk); #1 skip = 1'b0;
    wait_starts(s0 + 2, 200);
    vectors++; if (last_start - prev_start !== 20) begin errors++; $display("FAIL skip_spacing: got %0d cycles, required 20", last_start - prev_start); end
    wait_done(d0 + 1, 200);
    step(2);
    vectors++; if (start_cnt - s0 !== 3) begin errors++; $display("FAIL skip_starts: got %0d, required 3", start_cnt - s0); end
    vectors++; if (exp_q.size() !== 0) begin errors++; $display("FAIL skip_pending: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_full_song();
    int s0, d0;
    s0 = start_cnt; d0 = done_cnt; loop = 1'b0; song_sel = 2'd3;
    for (int a = 0; a < 64; a++) push_exp(8'(192 + a));
    pulse_play();
    step(2);
    song_sel = 2'd0;
    wait_done(d0 + 1, 3000);
    step(3);
    vectors++; if (start_cnt - s0 !== 64) begin errors++; $display("FAIL full_starts: got %0d, required 64", start_cnt - s0); end
    vectors++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done: got %0d, required 1", done_cnt - d0); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy: got %b, required 0", busy); end
    exp_q.delete();
  endtask

  task automatic test_abort();
    int s0;
    s0 = start_cnt; loop = 1'b0; song_sel = 2'd0;
    push_exp(8'd0);
    pulse_play();
    wait_starts(s0 + 1, 200);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    vectors++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL rst_addr: got %0d, required 0", rom_addr); end
    vectors++; if (snd_note !== 3'd0) begin errors++; $display("FAIL rst_note: got %0d, required 0", snd_note); end
    step(50);
    vectors++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL rst_quiet: got %0d, required 1", start_cnt - s0); end
    exp_q.delete();

    s0 = start_cnt;
    push_exp(8'd0);
    pulse_play();
    wait_starts(s0 + 1, 200);
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy: got %b, required 0", busy); end
    vectors++; if (snd_note !== 3'd3) begin errors++; $display("FAIL en_hold: got %0d, required 3", snd_note); end
    en = 1'b1;
    step(40);
    vectors++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL en_quiet: got %0d, required 1", start_cnt - s0); end
    exp_q.delete();

    s0 = start_cnt;
    push_exp(8'd0);
    pulse_play();
    wait_starts(s0 + 1, 200);
    @(posedge clk); #1 pause = 1'b1; skip = 1'b1;
    @(posedge clk); #1 pause = 1'b0; skip = 1'b0;
    repeat (17) @(negedge clk);
    #1;
    vectors++; if (note_idx !== 6'd0) begin errors++; $display("FAIL pauseskip_early: got idx %0d, required 0", note_idx); end
    step(12);
    vectors++; if (note_idx !== 6'd1) begin errors++; $display("FAIL pauseskip_idx: got %0d, required 1", note_idx); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL pauseskip_busy: got %b, required 1", busy); end
    vectors++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL pauseskip_starts: got %0d, required 1", start_cnt - s0); end
    en = 1'b0;
    step(2);
    en = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 8'd0;
    rom[0] = ent(1'b0, 2'd1, 3'd3, 2'd2);
    rom[1] = ent(1'b0, 2'd2, 3'd5, 2'd1);
    rom[2] = ent(1'b0, 2'd3, 3'd0, 2'd3);
    rom[3] = ent(1'b1, 2'd0, 3'd0, 2'd0);
    for (int a = 0; a < 64; a++)
      rom[192 + a] = ent(1'b0, 2'(a % 4), 3'((a / 4) % 8), 2'((a / 2) % 4));
    test_reset();
    test_basic();
    test_loop();
    test_pause();
    test_skip();
    test_full_song();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
